// File: rtl/fpu_pkg.sv
// fpu_pkg: shared floating-point constants, the fdiv state enumeration
// and a small field-decoding helper for the single-precision datapath.
// Contains no ports. Consumed by fdiv_mant and fdiv_seq through
// import fpu_pkg::*.
package fpu_pkg;

   localparam int           FP_EXP_W   = 8;
   localparam int           FP_MAN_W   = 23;
   localparam int           FP_BIAS    = 127;
   localparam logic [7:0]   FP_EXP_MAX = 8'hFF;
   localparam int           FDIV_ITER  = 26;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_NORM = 2'd2,
      ST_DONE = 2'd3
   } fdiv_state_e;

   // Denormals are flushed, so a zero exponent field means the operand is zero.
   function automatic logic fp_exp_is_zero(input logic [FP_EXP_W-1:0] e);
      return (e == 8'h00);
   endfunction

endpackage

// File: rtl/fdiv_mant.sv
// fdiv_mant: iterative restoring radix-2 mantissa divider.
// Computes q = floor(a * 2^25 / b) for 24-bit normalised mantissas
// (a, b in [2^23, 2^24)), one quotient bit per clock, FDIV_ITER clocks.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   start - load a/b and begin a new division (restarts any running one)
//   a, b  - dividend / divisor mantissas with hidden bit
//   q     - 26-bit quotient, valid while done is high and held afterwards
//   done  - one-cycle pulse when the last quotient bit has been produced
module fdiv_mant
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [23:0] a,
   input  logic [23:0] b,
   output logic [25:0] q,
   output logic        done
);

   logic [25:0] rem_r;
   logic [25:0] div_r;
   logic [25:0] q_r;
   logic [4:0]  cnt_r;
   logic        busy_r;
   logic        done_r;
   logic        rem_ge_s;
   logic [25:0] rem_nxt_s;

   // Trial subtraction for the current quotient bit. The remainder stays
   // below twice the divisor, so 26 bits never overflow.
   always_comb begin
      rem_ge_s  = 1'b0;
      rem_nxt_s = rem_r;
      if (rem_r >= div_r) begin
         rem_ge_s  = 1'b1;
         rem_nxt_s = rem_r - div_r;
      end else begin
         rem_ge_s  = 1'b0;
         rem_nxt_s = rem_r;
      end
   end

   // Iteration state: load on start, then shift one quotient bit in per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_r  <= 26'd0;
         div_r  <= 26'd0;
         q_r    <= 26'd0;
         cnt_r  <= 5'd0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else if (start) begin
         rem_r  <= {2'b00, a};
         div_r  <= {2'b00, b};
         q_r    <= 26'd0;
         cnt_r  <= 5'd0;
         busy_r <= 1'b1;
         done_r <= 1'b0;
      end else if (busy_r) begin
         q_r   <= {q_r[24:0], rem_ge_s};
         rem_r <= rem_nxt_s << 1;
         cnt_r <= cnt_r + 5'd1;
         if (cnt_r == 5'(FDIV_ITER - 1)) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
         end else begin
            done_r <= 1'b0;
         end
      end else begin
         done_r <= 1'b0;
      end
   end

   assign q    = q_r;
   assign done = done_r;

endmodule

// File: rtl/fdiv_seq.sv
// fdiv_seq: sequential IEEE-754 single-precision divider y = x1 / x2 with
// valid/ready handshakes on both sides. Denormals flush to zero; rounding
// is round-half-up; exponent overflow/underflow saturates and raises ovf.
// Optional feature macro: FDIV_SPECIAL_EN -- zero/inf/nan operands bypass
// the mantissa divider and produce a result one cycle after accept.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   in_valid, in_ready  - operand handshake (in_ready high only in IDLE)
//   x1, x2              - dividend / divisor
//   out_valid, out_ready- result handshake
//   y, ovf              - quotient and exponent-saturation flag
module fdiv_seq
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y,
   output logic        ovf
);

   fdiv_state_e state_r;
   logic        in_ready_r;
   logic        out_valid_r;
   logic [31:0] y_r;
   logic        ovf_r;
   logic        ys_r;
   logic [7:0]  ex1_r;
   logic [7:0]  ex2_r;

   logic        accept_s;
   logic        start_s;
   logic        ys_in_s;
   logic        mant_done_s;
   logic [25:0] q_s;

   logic [23:0]       man_s;
   logic              guard_s;
   logic              ebias_s;
   logic [24:0]       sum_s;
   logic              carry_s;
   logic [22:0]       frac_s;
   logic signed [9:0] exp_s;
   logic [31:0]       res_y_s;
   logic              res_ovf_s;

`ifdef FDIV_SPECIAL_EN
   logic        special_s;
   logic [31:0] spec_y_s;
   logic        spec_ovf_s;
   logic        spec_hit_r;
   logic [31:0] spec_y_r;
   logic        spec_ovf_r;
`endif

   assign accept_s = in_valid & in_ready_r;
   assign ys_in_s  = x1[31] ^ x2[31];

`ifdef FDIV_SPECIAL_EN
   // Special-operand decode on the raw inputs; priority order matters
   // (e.g. inf/0 reports inf, 0/0 reports the divide-by-zero result).
   always_comb begin
      special_s  = 1'b1;
      spec_ovf_s = 1'b0;
      spec_y_s   = 32'h0000_0000;
      if (x1[30:23] == FP_EXP_MAX) begin
         spec_y_s = {ys_in_s, FP_EXP_MAX, x1[22:0]};
      end else if (x2[30:23] == FP_EXP_MAX) begin
         spec_y_s = {ys_in_s, 31'd0};
      end else if (fp_exp_is_zero(x2[30:23])) begin
         spec_y_s   = {ys_in_s, FP_EXP_MAX, 23'd0};
         spec_ovf_s = 1'b1;
      end else if (fp_exp_is_zero(x1[30:23])) begin
         spec_y_s = {ys_in_s, 31'd0};
      end else begin
         special_s = 1'b0;
      end
   end

   assign start_s = accept_s & ~special_s;
`else
   assign start_s = accept_s;
`endif

   // Mantissas are taken straight from the inputs on the accept cycle;
   // the divider registers them, so later input changes are harmless.
   fdiv_mant u_mant (
      .clk   (clk),
      .rst   (rst),
      .start (start_s),
      .a     ({1'b1, x1[22:0]}),
      .b     ({1'b1, x2[22:0]}),
      .q     (q_s),
      .done  (mant_done_s)
   );

   // Normalise, round half-up, compute the biased exponent and saturate.
   always_comb begin
      man_s   = 24'd0;
      guard_s = 1'b0;
      ebias_s = 1'b0;
      if (q_s[25]) begin
         man_s   = q_s[25:2];
         guard_s = q_s[1];
         ebias_s = 1'b0;
      end else begin
         man_s   = q_s[24:1];
         guard_s = q_s[0];
         ebias_s = 1'b1;
      end
      sum_s   = {1'b0, man_s} + {24'd0, guard_s};
      carry_s = sum_s[24];
      // A rounding carry means the mantissa became 2.0: shift right one.
      if (carry_s) begin
         frac_s = sum_s[23:1];
      end else begin
         frac_s = sum_s[22:0];
      end
      exp_s = $signed({2'b00, ex1_r}) - $signed({2'b00, ex2_r})
            + $signed(10'(FP_BIAS))
            - $signed({9'd0, ebias_s}) + $signed({9'd0, carry_s});
      if (exp_s >= 10'sd255) begin
         res_y_s   = {ys_r, FP_EXP_MAX, 23'd0};
         res_ovf_s = 1'b1;
      end else if (exp_s <= 10'sd0) begin
         res_y_s   = {ys_r, 8'h00, 23'd0};
         res_ovf_s = 1'b1;
      end else begin
         res_y_s   = {ys_r, exp_s[7:0], frac_s};
         res_ovf_s = 1'b0;
      end
`ifdef FDIV_SPECIAL_EN
      if (spec_hit_r) begin
         res_y_s   = spec_y_r;
         res_ovf_s = spec_ovf_r;
      end else begin
         res_y_s   = res_y_s;
         res_ovf_s = res_ovf_s;
      end
`endif
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         y_r         <= 32'h0000_0000;
         ovf_r       <= 1'b0;
         ys_r        <= 1'b0;
         ex1_r       <= 8'h00;
         ex2_r       <= 8'h00;
`ifdef FDIV_SPECIAL_EN
         spec_hit_r  <= 1'b0;
         spec_y_r    <= 32'h0000_0000;
         spec_ovf_r  <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  in_ready_r <= 1'b0;
                  ys_r       <= ys_in_s;
                  ex1_r      <= x1[30:23];
                  ex2_r      <= x2[30:23];
`ifdef FDIV_SPECIAL_EN
                  spec_hit_r <= special_s;
                  spec_y_r   <= spec_y_s;
                  spec_ovf_r <= spec_ovf_s;
                  // Specials skip DIV; one NORM cycle registers the result.
                  state_r    <= special_s ? ST_NORM : ST_DIV;
`else
                  state_r    <= ST_DIV;
`endif
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_DIV: begin
               if (mant_done_s) begin
                  state_r <= ST_NORM;
               end else begin
                  state_r <= ST_DIV;
               end
            end
            ST_NORM: begin
               y_r         <= res_y_s;
               ovf_r       <= res_ovf_s;
               out_valid_r <= 1'b1;
               state_r     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end else begin
                  state_r <= ST_DONE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign y         = y_r;
   assign ovf       = ovf_r;

endmodule
